// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, FSM state encoding and instruction field slice macros for cpu_core.
// Latency: none (declarations only).
// Backpressure: n/a.
`ifndef CPU_PKG_MACROS
`define CPU_PKG_MACROS
// Instruction fields: opcode in the top 5 bits, register select just above the operand, operand at the bottom.
`define CPU_OPC(ir, ww)    ir[(ww)-1 -: 5]
`define CPU_RS(ir, aw, rw) ir[(rw)-1+(aw) : (aw)]
`define CPU_OPD(ir, aw)    ir[(aw)-1 : 0]
`endif

package cpu_pkg;

    localparam int OPC_W = 5;
    typedef logic [OPC_W-1:0] opc_t;

    localparam opc_t OP_NOP   = 5'd0;
    localparam opc_t OP_LOADI = 5'd1;
    localparam opc_t OP_LOAD  = 5'd2;
    localparam opc_t OP_STO   = 5'd3;
    localparam opc_t OP_ADD   = 5'd4;
    localparam opc_t OP_SUB   = 5'd5;
    localparam opc_t OP_JMP   = 5'd6;
    localparam opc_t OP_JZ    = 5'd7;
    localparam opc_t OP_HALT  = 5'd8;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_WB      = 3'd4,
        ST_HALTED  = 3'd5
    } state_t;

    // Only LOAD and STO need a data-memory access after the fetch.
    function automatic logic is_mem_op(input opc_t op);
        return (op == OP_LOAD) || (op == OP_STO);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational add/subtract with signed-overflow flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module cpu_alu #(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_sub,
    output logic [WORD_W-1:0] o_y,
    output logic              o_ovf
);

    logic [WORD_W-1:0] w_b;

    // Subtract as a + ~b + 1; overflow when both addends share a sign the result does not.
    always_comb begin
        w_b   = i_sub ? ~i_b : i_b;
        o_y   = i_a + w_b + {{(WORD_W-1){1'b0}}, i_sub};
        o_ovf = (i_a[WORD_W-1] == w_b[WORD_W-1]) && (o_y[WORD_W-1] != i_a[WORD_W-1]);
    end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: multicycle accumulator CPU with register file, req/ack memory port and optional boot clear.
// Latency: 3 cycles per non-memory instruction, 4 for LOAD/STO, plus one per memory wait cycle.
// Backpressure: memory request fields are held until mem_ack; CPU_CORE_PERF_EN adds the retired counter.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int NUM_REGS   = 8,
    parameter int BOOT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              boot,
    output logic              halted,
    output logic              ovfl
`ifdef CPU_CORE_PERF_EN
    ,
    output logic [31:0]       retired
`endif
);

    localparam int RSEL_W = $clog2(NUM_REGS);

    state_t            r_state, w_state_nxt;
    logic [WORD_W-1:0] r_ir, r_mdr;
    logic [ADDR_W-1:0] r_pc, r_boot_addr;
    logic              r_boot, r_halted, r_ovfl;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic [WORD_W-1:0] r_regs [NUM_REGS];

    opc_t              w_opc;
    logic [RSEL_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_opd;
    logic [WORD_W-1:0] w_rs_val;
    logic [WORD_W-1:0] w_alu_y;
    logic              w_alu_ovf;
    logic              w_ack;
    logic [ADDR_W-1:0] w_pc_inc, w_pc_br;

    logic              w_req_nxt, w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [WORD_W-1:0] w_wdata_nxt;
    logic              w_ir_ld, w_mdr_ld;
    logic [ADDR_W-1:0] w_boot_addr_nxt;
    logic              w_boot_nxt, w_halted_nxt;
    logic              w_pc_ld;
    logic [ADDR_W-1:0] w_pc_val;
    logic              w_rf_we;
    logic [RSEL_W-1:0] w_rf_sel;
    logic [WORD_W-1:0] w_rf_dat;
    logic              w_ovfl_set;

    assign w_opc    = `CPU_OPC(r_ir, WORD_W);
    assign w_rs     = `CPU_RS(r_ir, ADDR_W, RSEL_W);
    assign w_opd    = `CPU_OPD(r_ir, ADDR_W);
    assign w_rs_val = r_regs[w_rs];
    assign w_ack    = r_mem_req & mem_ack;
    assign w_pc_inc = r_pc + ADDR_W'(1);

    // Branch target: JMP always, JZ only when the accumulator is zero; pc wraps naturally.
    always_comb begin
        w_pc_br = w_pc_inc;
        if (w_opc == OP_JMP)
            w_pc_br = w_opd;
        else if ((w_opc == OP_JZ) && (r_regs[0] == '0))
            w_pc_br = w_opd;
    end

    cpu_alu #(
        .WORD_W (WORD_W)
    ) u_alu (
        .i_a   (r_regs[0]),
        .i_b   (w_rs_val),
        .i_sub (w_opc == OP_SUB),
        .o_y   (w_alu_y),
        .o_ovf (w_alu_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= (BOOT_CLEAR != 0) ? ST_BOOT : ST_FETCH;
        else
            r_state <= w_state_nxt;
    end

    // Next-state, memory request and datapath control; a request is raised on entry to a memory state
    // (or in its first cycle if entered with req low) and always drops the cycle after its ack.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_mem_req;
        w_we_nxt        = r_mem_we;
        w_addr_nxt      = r_mem_addr;
        w_wdata_nxt     = r_mem_wdata;
        w_ir_ld         = 1'b0;
        w_mdr_ld        = 1'b0;
        w_boot_addr_nxt = r_boot_addr;
        w_boot_nxt      = r_boot;
        w_halted_nxt    = r_halted;
        w_pc_ld         = 1'b0;
        w_pc_val        = r_pc;
        w_rf_we         = 1'b0;
        w_rf_sel        = w_rs;
        w_rf_dat        = WORD_W'(w_opd);
        w_ovfl_set      = 1'b0;

        if (w_ack)
            w_req_nxt = 1'b0;

        case (r_state)
            ST_BOOT: begin
                if (!r_mem_req) begin
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_boot_addr;
                    w_wdata_nxt = '0;
                end else if (mem_ack) begin
                    if (r_boot_addr == '1) begin
                        w_state_nxt = ST_FETCH;
                        w_boot_nxt  = 1'b0;
                        w_pc_ld     = 1'b1;
                        w_pc_val    = '0;
                    end else begin
                        w_boot_addr_nxt = r_boot_addr + ADDR_W'(1);
                    end
                end
            end
            ST_FETCH: begin
                if (!r_mem_req) begin
                    w_req_nxt  = 1'b1;
                    w_we_nxt   = 1'b0;
                    w_addr_nxt = r_pc;
                end else if (mem_ack) begin
                    w_ir_ld     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_mem_op(w_opc)) begin
                    w_state_nxt = ST_EXECUTE;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = (w_opc == OP_STO);
                    w_addr_nxt  = w_opd;
                    w_wdata_nxt = w_rs_val;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_EXECUTE: begin
                if (w_ack) begin
                    w_mdr_ld    = (w_opc == OP_LOAD);
                    w_state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                case (w_opc)
                    OP_LOADI: w_rf_we = 1'b1;
                    OP_LOAD: begin
                        w_rf_we  = 1'b1;
                        w_rf_dat = r_mdr;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rf_we    = 1'b1;
                        w_rf_sel   = '0;
                        w_rf_dat   = w_alu_y;
                        w_ovfl_set = w_alu_ovf;
                    end
                    default: ;
                endcase
                if (w_opc == OP_HALT) begin
                    w_state_nxt  = ST_HALTED;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_FETCH;
                    w_pc_ld     = 1'b1;
                    w_pc_val    = w_pc_br;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = w_pc_br;
                end
            end
            ST_HALTED: ;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Datapath registers: memory port, ir/mdr, pc, boot counter, flags and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ir        <= '0;
            r_mdr       <= '0;
            r_pc        <= '0;
            r_boot_addr <= '0;
            r_boot      <= (BOOT_CLEAR != 0);
            r_halted    <= 1'b0;
            r_ovfl      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_mem_req   <= w_req_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_boot_addr <= w_boot_addr_nxt;
            r_boot      <= w_boot_nxt;
            r_halted    <= w_halted_nxt;
            if (w_ovfl_set)
                r_ovfl <= 1'b1;
            if (w_ir_ld)
                r_ir <= mem_rdata;
            if (w_mdr_ld)
                r_mdr <= mem_rdata;
            if (w_pc_ld)
                r_pc <= w_pc_val;
            if (w_rf_we)
                r_regs[w_rf_sel] <= w_rf_dat;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign boot      = r_boot;
    assign halted    = r_halted;
    assign ovfl      = r_ovfl;

`ifdef CPU_CORE_PERF_EN
    logic [31:0] r_retired;

    // Retired-instruction counter: one per write-back, so it stays frozen in BOOT and HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_retired <= '0;
        else if (r_state == ST_WB)
            r_retired <= r_retired + 32'd1;
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_cpu_core.sv
`timescale 1ns/1ps
module tb_cpu_core;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, boot, halted, ovfl;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;
`ifdef CPU_CORE_PERF_EN
    logic [31:0] retired;
`endif

    always #5 clk = ~clk;

    cpu_core #(.WORD_W(16), .ADDR_W(8), .NUM_REGS(8), .BOOT_CLEAR(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .boot      (boot),
        .halted    (halted),
        .ovfl      (ovfl)
`ifdef CPU_CORE_PERF_EN
        ,
        .retired   (retired)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        ov;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] mem [256];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          max_dly = 0;
    bit          ack_hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input opc_t op, input int rs, input int opd);
        return {op, 3'(rs), 8'(opd)};
    endfunction

    task automatic push(input logic we, input int addr, input int data, input logic ov);
        txn_t t;
        t.we   = we;
        t.addr = 8'(addr);
        t.data = 16'(data);
        t.ov   = ov;
        exp_q.push_back(t);
    endtask

    // Memory model with random wait states; every acked transaction is matched against the scoreboard.
    bit          busy = 1'b0;
    int          wcnt = 0;
    logic        lat_we;
    logic [7:0]  lat_addr;
    logic [15:0] lat_wdata;
    always @(negedge clk) begin
        txn_t e;
        if (!rst_n) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
            check("req_drop_after_ack", mem_req, 0);
        end else if (mem_req && !ack_hold) begin
            if (!busy) begin
                busy      = 1'b1;
                wcnt      = (max_dly > 0) ? $urandom_range(max_dly, 0) : 0;
                lat_we    = mem_we;
                lat_addr  = mem_addr;
                lat_wdata = mem_wdata;
            end else begin
                check("hold_stable", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, lat_we, lat_addr, lat_wdata});
            end
            if (wcnt == 0) begin
                if (exp_q.size() == 0) begin
                    check("txn_unexpected_qsize", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_we", mem_we, e.we);
                    check("txn_addr", mem_addr, e.addr);
                    if (e.we) begin
                        check("txn_wdata", mem_wdata, e.data);
                        check("txn_ovfl", ovfl, e.ov);
                    end
                end
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        mem_rdata = mem[mem_addr];
                mem_ack = 1'b1;
            end else begin
                wcnt--;
            end
        end
    end

    task automatic reset_and_boot(input int dly);
        int cnt;
        bit all_zero;
        rst_n    = 1'b0;
        ack_hold = 1'b0;
        max_dly  = dly;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_boot", boot, 1);
        check("rst_halted", halted, 0);
        check("rst_ovfl", ovfl, 0);
`ifdef CPU_CORE_PERF_EN
        check("rst_retired", retired, 0);
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'hFFFF;
            push(1'b1, i, 0, 1'b0);
        end
        rst_n = 1'b1;
        cnt = 0;
        while (boot && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        check("boot_done", boot, 0);
        if (dly == 0) check("boot_cycles", cnt, 512);
        check("boot_writes_left", exp_q.size(), 0);
        all_zero = 1'b1;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== 16'h0) all_zero = 1'b0;
        check("boot_mem_zero", all_zero, 1);
    endtask

    // From the end of boot: time from the first fetch request to halted.
    task automatic wait_halt(output int cyc);
        int guard = 0;
        while (!mem_req && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("first_fetch_addr", mem_addr, 0);
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("halt_reached", halted, 1);
    endtask

    task automatic quiet_after_halt();
        bit saw_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) saw_req = 1'b1;
        end
        check("no_req_after_halt", saw_req, 0);
        check("halted_stays", halted, 1);
    endtask

    task automatic load_prog2();
        mem[0] = ins(OP_LOADI, 1, 5);
        mem[1] = ins(OP_LOADI, 0, 7);
        mem[2] = ins(OP_ADD, 1, 0);
        mem[3] = ins(OP_STO, 0, 8'h20);
        mem[4] = ins(OP_HALT, 0, 0);
        for (int i = 0; i < 4; i++) push(1'b0, i, 0, 1'b0);
        push(1'b1, 8'h20, 12, 1'b0);
        push(1'b0, 4, 0, 1'b0);
    endtask

    task automatic run_prog2(input bit timed);
        int cyc;
        load_prog2();
        wait_halt(cyc);
        if (timed) check("prog2_cycles", cyc, 16);
        check("prog2_mem20", mem[8'h20], 12);
        check("prog2_q_empty", exp_q.size(), 0);
        check("prog2_ovfl", ovfl, 0);
        quiet_after_halt();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int guard;

        // Boot clear then the basic program with zero-wait memory.
        reset_and_boot(0);
        run_prog2(1'b1);

        // Same program with random 0-3 cycle ack delays.
        reset_and_boot(3);
        run_prog2(1'b0);

        // Signed overflow is sticky across a later non-overflowing ADD.
        reset_and_boot(0);
        mem[0] = ins(OP_LOAD, 0, 8'h40);
        mem[1] = ins(OP_LOADI, 1, 1);
        mem[2] = ins(OP_SUB, 1, 0);
        mem[3] = ins(OP_ADD, 1, 0);
        mem[4] = ins(OP_STO, 0, 8'h23);
        mem[5] = ins(OP_ADD, 1, 0);
        mem[6] = ins(OP_STO, 0, 8'h21);
        mem[7] = ins(OP_ADD, 1, 0);
        mem[8] = ins(OP_STO, 0, 8'h22);
        mem[9] = ins(OP_HALT, 0, 0);
        mem[8'h40] = 16'h7FFF;
        push(1'b0, 0, 0, 1'b0);
        push(1'b0, 8'h40, 0, 1'b0);
        for (int i = 1; i <= 4; i++) push(1'b0, i, 0, 1'b0);
        push(1'b1, 8'h23, 16'h7FFF, 1'b0);
        push(1'b0, 5, 0, 1'b0);
        push(1'b0, 6, 0, 1'b0);
        push(1'b1, 8'h21, 16'h8000, 1'b1);
        push(1'b0, 7, 0, 1'b0);
        push(1'b0, 8, 0, 1'b0);
        push(1'b1, 8'h22, 16'h8001, 1'b1);
        push(1'b0, 9, 0, 1'b0);
        wait_halt(cyc);
        check("ovf_sticky", ovfl, 1);
        check("ovf_mem21", mem[8'h21], 16'h8000);
        check("ovf_q_empty", exp_q.size(), 0);

        // JZ taken/not taken, JMP from 0xFF, then a NOP at 0xFF wrapping pc to 0.
        reset_and_boot(0);
        mem[8'h00] = ins(OP_JZ, 0, 8'h10);
        mem[8'h01] = ins(OP_HALT, 0, 0);
        mem[8'h10] = ins(OP_LOADI, 0, 3);
        mem[8'h11] = ins(OP_JZ, 0, 8'h30);
        mem[8'h12] = ins(OP_JMP, 0, 8'hFF);
        mem[8'hFF] = ins(OP_JMP, 0, 8'h40);
        mem[8'h40] = ins(OP_STO, 2, 8'hFF);
        mem[8'h41] = ins(OP_JMP, 0, 8'hFF);
        push(1'b0, 8'h00, 0, 1'b0);
        push(1'b0, 8'h10, 0, 1'b0);
        push(1'b0, 8'h11, 0, 1'b0);
        push(1'b0, 8'h12, 0, 1'b0);
        push(1'b0, 8'hFF, 0, 1'b0);
        push(1'b0, 8'h40, 0, 1'b0);
        push(1'b1, 8'hFF, 0, 1'b0);
        push(1'b0, 8'h41, 0, 1'b0);
        push(1'b0, 8'hFF, 0, 1'b0);
        push(1'b0, 8'h00, 0, 1'b0);
        push(1'b0, 8'h01, 0, 1'b0);
        wait_halt(cyc);
        check("jump_q_empty", exp_q.size(), 0);

        // Reset with a fetch outstanding and ack withheld: req drops without a clock edge.
        reset_and_boot(0);
        load_prog2();
        ack_hold = 1'b1;
        guard = 0;
        while (!mem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("held_req", mem_req, 1);
        check("held_addr", mem_addr, 0);
        #2 rst_n = 1'b0;
        #1 check("async_req_drop", mem_req, 0);
        reset_and_boot(0);
        run_prog2(1'b1);
`ifdef CPU_CORE_PERF_EN
        check("perf_retired", retired, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
